regfile_param: RTL and testbench

Parametrised multi-port register file for the next single-cycle/multi-cycle datapath generation, replacing the fixed 16x16, two-read-port file. It provides configurable width, depth and read-port count, optional write-to-read bypass, and a per-register busy scoreboard with reserve/release handshake for multi-cycle producers (loads, multiplier). It sits between decode (read and reserve addresses) and writeback (write and release).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/regfile_param.sv | 78 +++++++
 tb/tb_regfile_param.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised register file.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_W = 16;
  localparam int unsigned REGFILE_DEPTH  = 16;
  localparam int unsigned REGFILE_NUM_RD = 2;
  localparam int unsigned REGFILE_AW     = $clog2(REGFILE_DEPTH);

  typedef logic [REGFILE_AW-1:0]     reg_addr_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: decode/writeback side is master, the register file is slave.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGFILE_DATA_W,
  parameter int unsigned DEPTH  = REGFILE_DEPTH,
  parameter int unsigned NUM_RD = REGFILE_NUM_RD
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_rel;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic                     rsv_ack;
  logic [DEPTH-1:0]         busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_rel, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ack, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_rel, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ack, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags with reserve/release arbitration; release is applied before reserve.
module regfile_scoreboard #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic             wr_rel_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic             rsv_en_i,
  input  logic [AW-1:0]    rsv_addr_i,
  output logic             rsv_ack_o,
  output logic [DEPTH-1:0] busy_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             rel, rel_hit, rsv_zero;

  assign rel      = wr_en_i & wr_rel_i;
  assign rel_hit  = rel && (wr_addr_i == rsv_addr_i);
  assign rsv_zero = (ZERO_REG != 0) && (rsv_addr_i == '0);

  // A same-cycle release frees the register before the reserve is judged.
  assign rsv_ack_o = ~rst & rsv_en_i & ~rsv_zero & (~busy_q[rsv_addr_i] | rel_hit);

  always_comb begin
    busy_d = busy_q;
    if (rel) busy_d[wr_addr_i] = 1'b0;
    if (rsv_ack_o) busy_d[rsv_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle write (data and release) to matching reads.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = REGFILE_DATA_W,
  parameter int unsigned DEPTH    = REGFILE_DEPTH,
  parameter int unsigned NUM_RD   = REGFILE_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input logic       clk,
  input logic       rst,
  regfile_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_take;

  assign wr_take = bus.wr_en & ~((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_take) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.wr_en),
    .wr_rel_i   (bus.wr_rel),
    .wr_addr_i  (bus.wr_addr),
    .rsv_en_i   (bus.rsv_en),
    .rsv_addr_i (bus.rsv_addr),
    .rsv_ack_o  (bus.rsv_ack),
    .busy_o     (busy)
  );

  assign bus.busy_vec = busy;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     addr;
    logic              hit, rd_zero, bsy;
    logic [DATA_W-1:0] data;

    assign addr    = bus.rd_addr[p*AW +: AW];
    assign rd_zero = (ZERO_REG != 0) && (addr == '0);
`ifdef REGFILE_BYPASS_EN
    assign hit = wr_take && (bus.wr_addr == addr);
`else
    assign hit = 1'b0;
`endif

    // Outputs are forced to zero while reset is held, independent of the clock.
    always_comb begin
      data = mem_q[addr];
      bsy  = busy[addr];
      if (hit) begin
        data = bus.wr_data;
        bsy  = bsy & ~bus.wr_rel;
      end
      if (rst || rd_zero) data = '0;
      if (rst) bsy = 1'b0;
    end

    assign bus.rd_data[p*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[p]                  = bsy;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised scoreboard bench for regfile_param (32x32, three read ports, zero register).
module tb_regfile_param;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DEPTH    = 32;
  localparam int unsigned NUM_RD   = 3;
  localparam int unsigned ZERO_REG = 1;
  localparam int unsigned AW       = $clog2(DEPTH);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic                 rst;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_rel;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_addr;
  } stim_t;

  typedef struct packed {
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     rsv_ack;
    logic [DEPTH-1:0]         busy_vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

  regfile_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: plain arrays updated by the architectural rules.
  logic [DATA_W-1:0] m_mem  [DEPTH];
  logic              m_busy [DEPTH];
  stim_t             cur;
  exp_t              exp_q[$];
  int unsigned       n_cmp = 0;
  int unsigned       n_bad = 0;
  int unsigned       pop_id = 0;

  function automatic bit is_zero(int unsigned a);
    return (ZERO_REG != 0) && (a == 0);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t              e;
    int unsigned       a;
    logic [DATA_W-1:0] d;
    logic              b;
    e = '0;
    if (!s.rst) begin
      for (int p = 0; p < NUM_RD; p++) begin
        a = int'(s.rd_addr[p*AW +: AW]);
        d = m_mem[a];
        b = m_busy[a];
        if (BYPASS && s.wr_en && int'(s.wr_addr) == a && !is_zero(a)) begin
          d = s.wr_data;
          if (s.wr_rel) b = 1'b0;
        end
        if (is_zero(a)) d = '0;
        e.rd_data[p*DATA_W +: DATA_W] = d;
        e.rd_busy[p] = b;
      end
      e.rsv_ack = s.rsv_en && !is_zero(int'(s.rsv_addr)) &&
                  (!m_busy[s.rsv_addr] || (s.wr_en && s.wr_rel && s.wr_addr == s.rsv_addr));
    end
    for (int i = 0; i < DEPTH; i++) e.busy_vec[i] = m_busy[i];
    return e;
  endfunction

  function automatic void commit(stim_t s);
    logic ack;
    if (s.rst) begin
      model_clear();
      return;
    end
    ack = predict(s).rsv_ack;
    if (s.wr_en && !is_zero(int'(s.wr_addr))) m_mem[s.wr_addr] = s.wr_data;
    if (s.wr_en && s.wr_rel) m_busy[s.wr_addr] = 1'b0;
    if (ack) m_busy[s.rsv_addr] = 1'b1;
  endfunction

  // Inputs change 1 time unit after the rising edge; rst therefore toggles mid-cycle.
  task automatic step(stim_t s);
    @(posedge clk);
    commit(cur);
    #1;
    rst          = s.rst;
    bus.rd_addr  = s.rd_addr;
    bus.wr_en    = s.wr_en;
    bus.wr_addr  = s.wr_addr;
    bus.wr_data  = s.wr_data;
    bus.wr_rel   = s.wr_rel;
    bus.rsv_en   = s.rsv_en;
    bus.rsv_addr = s.rsv_addr;
    if (s.rst) model_clear();
    cur = s;
    exp_q.push_back(predict(s));
  endtask

  task automatic chk(string name, logic [127:0] got, logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, pop_id, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_data",  128'(bus.rd_data),  128'(e.rd_data));
      chk("rd_busy",  128'(bus.rd_busy),  128'(e.rd_busy));
      chk("rsv_ack",  128'(bus.rsv_ack),  128'(e.rsv_ack));
      chk("busy_vec", 128'(bus.busy_vec), 128'(e.busy_vec));
      pop_id++;
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [NUM_RD*AW-1:0] all_ports(int unsigned a);
    logic [NUM_RD*AW-1:0] v;
    for (int p = 0; p < NUM_RD; p++) v[p*AW +: AW] = AW'(a);
    return v;
  endfunction

  function automatic stim_t wr(int unsigned a, logic [DATA_W-1:0] d, logic rel);
    stim_t s;
    s = idle();
    s.wr_en = 1'b1; s.wr_addr = AW'(a); s.wr_data = d; s.wr_rel = rel;
    return s;
  endfunction

  function automatic stim_t rsv(int unsigned a);
    stim_t s;
    s = idle();
    s.rsv_en = 1'b1; s.rsv_addr = AW'(a);
    return s;
  endfunction

  function automatic stim_t rd(int unsigned a);
    stim_t s;
    s = idle();
    s.rd_addr = all_ports(a);
    return s;
  endfunction

  initial begin : driver
    stim_t s;
    cur = idle();
    cur.rst = 1'b1;
    model_clear();
    bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.wr_rel = 1'b0; bus.rsv_en = 1'b0; bus.rsv_addr = '0;

    // Held reset: outputs gated even with an active reserve request.
    s = rsv(3); s.rst = 1'b1; s.rd_addr = all_ports(5);
    step(s); step(s);
    step(idle());

    // Write and reserve r5, read it, then reset mid-cycle.
    s = wr(5, 'hBEEF, 1'b0); s.rsv_en = 1'b1; s.rsv_addr = 5;
    step(s);
    step(rd(5));
    s = rd(5); s.rst = 1'b1;
    step(s);
    step(rd(5));

    step(wr(3, 'h1234, 1'b0));
    step(rd(3));
    step(wr(0, 'hFFFF, 1'b0));
    step(rd(0));

    // Port 1 reads r7 while it is being written.
    step(wr(7, 'h0001, 1'b0));
    s = wr(7, 'hA5A5, 1'b0); s.rd_addr = all_ports(0); s.rd_addr[AW +: AW] = 7;
    step(s);
    step(rd(7));

    step(rsv(9));
    step(rsv(9));
    s = wr(9, 'h0042, 1'b1); s.rd_addr = all_ports(9);
    step(s);
    step(rd(9));

    // Same-cycle release and reserve of busy r4.
    step(rsv(4));
    s = wr(4, 'h0077, 1'b1); s.rsv_en = 1'b1; s.rsv_addr = 4; s.rd_addr = all_ports(4);
    step(s);
    step(rd(4));
    step(rsv(0));
    s = rd(4); s.wr_rel = 1'b1; s.wr_addr = 4;
    step(s);
    step(rd(4));

    for (int n = 0; n < 10000; n++) begin
      s = idle();
      s.rst     = ($urandom_range(0, 999) == 0);
      s.wr_en   = $urandom_range(0, 1) == 1;
      s.wr_addr = AW'($urandom_range(0, DEPTH - 1));
      s.wr_data = DATA_W'($urandom);
      s.wr_rel  = $urandom_range(0, 2) == 0;
      s.rsv_en  = $urandom_range(0, 1) == 1;
      s.rsv_addr = ($urandom_range(0, 3) == 0) ? s.wr_addr : AW'($urandom_range(0, DEPTH - 1));
      for (int p = 0; p < NUM_RD; p++) begin
        s.rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? s.wr_addr
                                                             : AW'($urandom_range(0, DEPTH - 1));
      end
      step(s);
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
